// File: rtl/dffsre_pkg.sv
// Shared constants and parameter checks for the dffsre pipeline bank.
// Imported by the stage and top modules.
package dffsre_pkg;

  localparam int GATE_ZERO = 0;
  localparam int GATE_HOLD = 1;

  function automatic bit params_ok(
    input int w,
    input int d,
    input int c
  );
    return (w >= 1) && (d >= 1) && (c >= 1);
  endfunction

endpackage

// File: rtl/dffsre_stage.sv
// One data word plus valid tag with reset > set > enable > hold priority.
// Set forces the data word to all-ones but leaves the valid tag alone.
module dffsre_stage
  import dffsre_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             S,
  input  logic             E,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge C) begin
    if (!R) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (!S) begin
      q <= '1;
    end else if (E) begin
      q       <= d;
      q_valid <= v;
    end
  end

endmodule

// File: rtl/dffsre_pipe_bank.sv
// Gated DEPTH-stage dffsre register pipeline with valid tags
// and a saturating accepted-word counter.
module dffsre_pipe_bank
  import dffsre_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 1,
  parameter int GATE_MODE = GATE_ZERO,
  parameter int CNT_W     = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             S,
  input  logic             E,
  input  logic             sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             out_valid,
  output logic [CNT_W-1:0] acc_cnt
);

  localparam bit PARAMS_OK = params_ok(WIDTH, DEPTH, CNT_W);

  if (!PARAMS_OK) begin : g_bad_params
    $error("dffsre_pipe_bank: WIDTH, DEPTH and CNT_W must be >= 1");
  end

  logic [WIDTH-1:0] data   [DEPTH];
  logic [WIDTH-1:0] st_d   [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] st_v;
  logic [WIDTH-1:0] gated;
  logic             take;

  assign take = in_valid & sel;

  // Hold mode recirculates the current stage-0 word when the gate is closed.
  always_comb begin
    gated = '0;
    unique case (1'b1)
      sel: gated = D;
      (!sel && GATE_MODE == GATE_HOLD): gated = data[0];
      default: gated = '0;
    endcase
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign st_d[k] = gated;
      assign st_v[k] = take;
    end else begin : g_body
      assign st_d[k] = data[k-1];
      assign st_v[k] = vld[k-1];
    end

    dffsre_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .C       (C),
      .R       (R),
      .S       (S),
      .E       (E),
      .d       (st_d[k]),
      .v       (st_v[k]),
      .q       (data[k]),
      .q_valid (vld[k])
    );
  end

  // Set does not touch the counter; it saturates instead of wrapping.
  always_ff @(posedge C) begin
    if (!R) begin
      acc_cnt <= '0;
    end else if (S && E && take && (acc_cnt != '1)) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  assign Q         = data[DEPTH-1];
  assign out_valid = vld[DEPTH-1];

endmodule

// File: tb/tb_dffsre_pipe_bank.sv
// Scoreboard bench for dffsre_pipe_bank across four configurations.
// Stimulus pushes expected outputs; a monitor pops and compares after each edge.
module tb_dffsre_pipe_bank;

  logic       clk = 1'b0;
  logic       R = 1'b0;
  logic       S = 1'b1;
  logic       E = 1'b0;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] D = 8'h00;

  logic [7:0] q_a, q_b, q_c;
  logic [0:0] q_d;
  logic       v_a, v_b, v_c, v_d;
  logic [7:0] c_a, c_b, c_d;
  logic [2:0] c_c;

  always #5 clk = ~clk;

  dffsre_pipe_bank #(
    .WIDTH(8), .DEPTH(3), .GATE_MODE(0), .CNT_W(8)
  ) u_a (
    .C(clk), .R(R), .S(S), .E(E), .sel(sel), .in_valid(in_valid),
    .D(D), .Q(q_a), .out_valid(v_a), .acc_cnt(c_a)
  );

  dffsre_pipe_bank #(
    .WIDTH(8), .DEPTH(3), .GATE_MODE(1), .CNT_W(8)
  ) u_b (
    .C(clk), .R(R), .S(S), .E(E), .sel(sel), .in_valid(in_valid),
    .D(D), .Q(q_b), .out_valid(v_b), .acc_cnt(c_b)
  );

  dffsre_pipe_bank #(
    .WIDTH(8), .DEPTH(1), .GATE_MODE(0), .CNT_W(3)
  ) u_c (
    .C(clk), .R(R), .S(S), .E(E), .sel(sel), .in_valid(in_valid),
    .D(D), .Q(q_c), .out_valid(v_c), .acc_cnt(c_c)
  );

  dffsre_pipe_bank #(
    .WIDTH(1), .DEPTH(1), .GATE_MODE(0), .CNT_W(8)
  ) u_d (
    .C(clk), .R(R), .S(S), .E(E), .sel(sel), .in_valid(in_valid),
    .D(D[0:0]), .Q(q_d), .out_valid(v_d), .acc_cnt(c_d)
  );

  typedef struct {
    int         id;
    logic [7:0] q;
    logic       v;
    logic [7:0] c;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic step(
    input logic       r,
    input logic       s,
    input logic       e,
    input logic       sl,
    input logic       iv,
    input logic [7:0] d,
    input int         id,
    input logic [7:0] eq,
    input logic       ev,
    input logic [7:0] ec,
    input string      nm
  );
    exp_t x;
    @(negedge clk);
    R = r; S = s; E = e; sel = sl; in_valid = iv; D = d;
    x.id = id; x.q = eq; x.v = ev; x.c = ec; x.nm = nm;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    exp_t       x;
    logic [7:0] aq, ac;
    logic       av;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      aq = '0; av = 1'b0; ac = '0;
      case (x.id)
        0: begin aq = q_a; av = v_a; ac = c_a; end
        1: begin aq = q_b; av = v_b; ac = c_b; end
        2: begin aq = q_c; av = v_c; ac = {5'b0, c_c}; end
        default: begin aq = {7'b0, q_d}; av = v_d; ac = c_d; end
      endcase
      total++;
      if (aq !== x.q) begin
        bad++;
        $display("FAIL %s Q: got %h want %h", x.nm, aq, x.q);
      end
      total++;
      if (av !== x.v) begin
        bad++;
        $display("FAIL %s out_valid: got %b want %b", x.nm, av, x.v);
      end
      total++;
      if (ac !== x.c) begin
        bad++;
        $display("FAIL %s acc_cnt: got %0d want %0d", x.nm, ac, x.c);
      end
    end
  end

  initial begin
    int n;
    // config A: DEPTH=3, zero gating
    step(0,1,1,1,1,8'hA5, 0, 8'h00,0,8'd0, "a_rst0");
    step(0,1,1,1,1,8'hA5, 0, 8'h00,0,8'd0, "a_rst1");
    step(1,1,1,1,1,8'hA5, 0, 8'h00,0,8'd1, "a_fill1");
    step(1,1,1,1,1,8'h3C, 0, 8'h00,0,8'd2, "a_fill2");
    step(1,1,1,1,1,8'hFF, 0, 8'hA5,1,8'd3, "a_out_a5");
    step(1,1,1,1,1,8'h11, 0, 8'h3C,1,8'd4, "a_out_3c");
    step(1,1,1,1,1,8'h22, 0, 8'hFF,1,8'd5, "a_out_ff");
    step(1,1,1,1,1,8'h33, 0, 8'h11,1,8'd6, "a_out_11");
    for (int i = 0; i < 4; i++)
      step(1,1,0,1,1,8'h99, 0, 8'h11,1,8'd6, "a_stall");
    step(1,1,1,0,1,8'h77, 0, 8'h22,1,8'd6, "a_resume_22");
    step(1,1,1,0,1,8'h77, 0, 8'h33,1,8'd6, "a_resume_33");
    step(1,1,1,0,1,8'h77, 0, 8'h00,0,8'd6, "a_gate_zero");
    step(1,1,1,1,1,8'h01, 0, 8'h00,0,8'd7, "a_refill1");
    step(1,1,1,1,1,8'h02, 0, 8'h00,0,8'd8, "a_refill2");
    step(1,1,1,1,1,8'h03, 0, 8'h01,1,8'd9, "a_full");
    step(1,0,1,1,1,8'h00, 0, 8'hFF,1,8'd9, "a_set");
    step(1,1,1,1,0,8'h00, 0, 8'hFF,1,8'd9, "a_set_shift");
    step(0,0,1,1,1,8'h00, 0, 8'h00,0,8'd0, "a_rst_and_set");
    step(1,1,0,1,1,8'h00, 0, 8'h00,0,8'd0, "a_after_rst");
    // config B: DEPTH=3, hold gating
    step(0,1,1,1,1,8'h00, 1, 8'h00,0,8'd0, "b_rst");
    step(1,1,1,1,1,8'h5A, 1, 8'h00,0,8'd1, "b_load");
    step(1,1,1,0,1,8'h77, 1, 8'h00,0,8'd1, "b_hold1");
    step(1,1,1,0,1,8'h77, 1, 8'h5A,1,8'd1, "b_hold2");
    step(1,1,1,0,1,8'h77, 1, 8'h5A,0,8'd1, "b_hold3");
    // config C: DEPTH=1, 3-bit counter saturates
    step(0,1,1,1,1,8'h00, 2, 8'h00,0,8'd0, "c_rst");
    for (int i = 1; i <= 10; i++) begin
      n = (i > 7) ? 7 : i;
      step(1,1,1,1,1,8'(8'h10 + i), 2, 8'(8'h10 + i),1,8'(n), "c_count");
    end
    step(1,1,0,1,1,8'h55, 2, 8'h1A,1,8'd7, "c_stall");
    step(0,1,1,1,1,8'h55, 2, 8'h00,0,8'd0, "c_rst_cnt");
    // config D: DEPTH=1, WIDTH=1
    step(0,1,1,1,1,8'h01, 3, 8'h00,0,8'd0, "d_rst");
    step(1,1,1,0,1,8'h01, 3, 8'h00,0,8'd0, "d_gate_zero");
    step(1,1,1,1,1,8'h01, 3, 8'h01,1,8'd1, "d_capture");
    step(0,1,1,1,1,8'h01, 3, 8'h00,0,8'd0, "d_rst_next");
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
